// File: rtl/shiftreg_pkg.sv
// shiftreg_pkg: mode type and encodings shared by the shift/rotate family
package shiftreg_pkg;
  typedef logic [1:0] mode_t;
  localparam mode_t MODE_HOLD = 2'b00;
  localparam mode_t MODE_SHR  = 2'b01;
  localparam mode_t MODE_SHL  = 2'b10;
  localparam mode_t MODE_LOAD = 2'b11;
endpackage

// File: rtl/shiftreg_universal_if.sv
// shiftreg_universal_if: control, serial and parallel signals of the universal shift register
interface shiftreg_universal_if #(parameter int WIDTH = 8);
  import shiftreg_pkg::*;
  localparam int CW = $clog2(WIDTH);
  logic en;
  mode_t mode;
  logic sin_r;
  logic sin_l;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic sout_r;
  logic sout_l;
  logic [CW-1:0] cnt;
  logic done;
  modport master (output en, mode, sin_r, sin_l, d, input q, sout_r, sout_l, cnt, done);
  modport slave (input en, mode, sin_r, sin_l, d, output q, sout_r, sout_l, cnt, done);
endinterface

// File: rtl/shiftreg_cell.sv
// shiftreg_cell: one register bit, 4:1 mux (hold/from right neighbour/from left neighbour/load) plus flop
module shiftreg_cell
  import shiftreg_pkg::*;
(
  input  logic  clk,
  input  logic  clr,
  input  logic  en,
  input  mode_t mode,
  input  logic  from_hi,
  input  logic  from_lo,
  input  logic  d,
  output logic  q
);
  always_ff @(posedge clk or negedge clr)
    if (!clr) q <= 1'b0;
    else if (en) q <= mode == MODE_SHR ? from_hi : mode == MODE_SHL ? from_lo : mode == MODE_LOAD ? d : q;
endmodule

// File: rtl/shiftreg_universal.sv
// shiftreg_universal: WIDTH-bit bidirectional shift register with load, clock enable
// and a frame counter that pulses done after every WIDTH shifts
module shiftreg_universal
  import shiftreg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic clr,
  shiftreg_universal_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0] q;
  logic [WIDTH+1:0] ext;
  logic [CW-1:0] cnt;
  logic done;
  logic shift;
  logic wrap;
  // serial inputs pad both ends so every cell sees uniform neighbours
  assign ext = {bus.sin_r, q, bus.sin_l};
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    shiftreg_cell u_cell (
      .clk     (clk),
      .clr     (clr),
      .en      (bus.en),
      .mode    (bus.mode),
      .from_hi (ext[i+2]),
      .from_lo (ext[i]),
      .d       (bus.d[i]),
      .q       (q[i])
    );
  end
  assign shift = bus.en && (bus.mode == MODE_SHR || bus.mode == MODE_SHL);
  assign wrap  = cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= shift && wrap;
      if (bus.en && bus.mode == MODE_LOAD) cnt <= '0;
      else if (shift) cnt <= wrap ? '0 : cnt + 1'b1;
    end
  assign bus.q      = q;
  assign bus.sout_r = q[0];
  assign bus.sout_l = q[WIDTH-1];
  assign bus.cnt    = cnt;
  assign bus.done   = done;
endmodule

// File: tb/tb_shiftreg_universal.sv
// tb_shiftreg_universal: randomized and directed stimulus against an arithmetic reference
// model, with expected states queued by the driver and compared by an independent monitor
module tb_shiftreg_universal;
  import shiftreg_pkg::*;
  localparam int W  = 8;
  localparam int CW = $clog2(W);
  typedef struct packed {
    logic [W-1:0]  q;
    logic [CW-1:0] cnt;
    logic          done;
  } exp_t;
  logic clk = 1'b0;
  logic clr = 1'b0;
  shiftreg_universal_if #(.WIDTH(W)) bus ();
  shiftreg_universal #(.WIDTH(W)) dut (.clk(clk), .clr(clr), .bus(bus));
  always #5 clk = ~clk;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int m_q = 0;
  int m_sc = 0;
  bit m_done = 1'b0;
  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endfunction
  task automatic step(input logic e, input mode_t m, input logic sr, input logic sl, input logic [W-1:0] dd);
    logic [31:0] mq;
    @(negedge clk);
    bus.en = e; bus.mode = m; bus.sin_r = sr; bus.sin_l = sl; bus.d = dd;
    if (!clr) begin
      m_q = 0; m_sc = 0; m_done = 1'b0;
    end else if (!e || m == MODE_HOLD) m_done = 1'b0;
    else if (m == MODE_LOAD) begin
      m_q = int'(dd); m_sc = 0; m_done = 1'b0;
    end else begin
      m_q = m == MODE_SHR ? m_q / 2 + int'(sr) * (1 << (W - 1)) : (m_q * 2) % (1 << W) + int'(sl);
      m_sc++;
      m_done = (m_sc % W) == 0;
    end
    mq = m_q;
    sb.push_back('{q: mq[W-1:0], cnt: CW'(m_sc % W), done: m_done});
  endtask
  task automatic rnd_step();
    step($urandom_range(0, 3) != 0, mode_t'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), W'($urandom));
  endtask
  task automatic release_clr();
    @(negedge clk);
    bus.en = 1'b0;
    clr = 1'b1;
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("q", 64'(bus.q), 64'(e.q));
        chk("cnt", 64'(bus.cnt), 64'(e.cnt));
        chk("done", 64'(bus.done), 64'(e.done));
        chk("sout_r", 64'(bus.sout_r), 64'(e.q[0]));
        chk("sout_l", 64'(bus.sout_l), 64'(e.q[W-1]));
      end
    end
  end
  initial begin : driver
    bus.en = 1'b0; bus.mode = MODE_HOLD; bus.sin_r = 1'b0; bus.sin_l = 1'b0; bus.d = '0;
    #1;
    chk("reset_q", 64'(bus.q), 64'h0);
    chk("reset_cnt", 64'(bus.cnt), 64'h0);
    chk("reset_done", 64'(bus.done), 64'h0);
    repeat (6) rnd_step();
    release_clr();
    step(1'b1, MODE_LOAD, 1'b0, 1'b0, 8'hA5);
    repeat (W) step(1'b1, MODE_SHR, 1'b0, 1'b0, 8'h00);
    repeat (3) step(1'b1, MODE_SHL, 1'b0, 1'b1, 8'h00);
    step(1'b1, MODE_LOAD, 1'b0, 1'b0, 8'h3C);
    repeat (4) step(1'b0, MODE_SHR, 1'b1, 1'b1, 8'h00);
    step(1'b1, MODE_HOLD, 1'b1, 1'b1, 8'h00);
    repeat (5) step(1'b1, MODE_SHL, 1'b0, 1'b1, 8'h00);
    step(1'b1, MODE_LOAD, 1'b0, 1'b0, 8'hFF);
    repeat (W + 1) step(1'b1, MODE_SHR, 1'b0, 1'b0, 8'h00);
    step(1'b1, MODE_LOAD, 1'b0, 1'b0, 8'h81);
    repeat (3) step(1'b1, MODE_SHR, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    bus.en = 1'b1; bus.mode = MODE_SHL;
    #1 clr = 1'b0;
    #1;
    chk("async_q", 64'(bus.q), 64'h0);
    chk("async_cnt", 64'(bus.cnt), 64'h0);
    chk("async_done", 64'(bus.done), 64'h0);
    @(posedge clk);
    #1;
    chk("held_q", 64'(bus.q), 64'h0);
    chk("held_cnt", 64'(bus.cnt), 64'h0);
    m_q = 0; m_sc = 0; m_done = 1'b0;
    release_clr();
    repeat (W + 1) step(1'b1, MODE_SHR, 1'b1, 1'b0, 8'h00);
    repeat (400) rnd_step();
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", 64'(sb.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
